// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - Block copy/fill engine driving a single-port byte memory
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] fill_value,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] DataAddress,
    output logic          ReadMem,
    output logic          WriteMem,
    output logic [DW-1:0] DataIn,
    input  logic [DW-1:0] DataOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW-1:0] count;
    logic [DW-1:0] hold;
    logic [DW-1:0] fill_r;
    logic          mode_r;
    logic          backward;

    logic [AW-1:0] diff;
    logic          go_back;
    logic          accept;

    // Overlapping copy where the destination lies just above the source must
    // run top-down, otherwise source bytes are overwritten before being read.
    assign diff    = dst_addr - src_addr;
    assign go_back = !mode && (diff != '0) && (diff < len);
    assign accept  = (state == IDLE) && start;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            hold     <= '0;
            fill_r   <= '0;
            mode_r   <= 1'b0;
            backward <= 1'b0;
        end else begin
            if (accept) begin
                mode_r   <= mode;
                fill_r   <= fill_value;
                count    <= len;
                backward <= go_back;
                if (go_back) begin
                    src_ptr <= src_addr + len - AW'(1);
                    dst_ptr <= dst_addr + len - AW'(1);
                end else begin
                    src_ptr <= src_addr;
                    dst_ptr <= dst_addr;
                end
            end
            if (state == READ) begin
                hold <= DataOut;
            end
            if (state == WRITE) begin
                count <= count - AW'(1);
                if (backward) begin
                    src_ptr <= src_ptr - AW'(1);
                    dst_ptr <= dst_ptr - AW'(1);
                end else begin
                    src_ptr <= src_ptr + AW'(1);
                    dst_ptr <= dst_ptr + AW'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_nxt = DONE;
                    end else if (mode) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                if (count == AW'(1)) begin
                    state_nxt = DONE;
                end else if (mode_r) begin
                    state_nxt = WRITE;
                end else begin
                    state_nxt = READ;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Gating the write strobe with reset keeps an aborted write from landing
    // on the memory even before the state register has visibly cleared.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        DataAddress = '0;
        ReadMem     = 1'b0;
        WriteMem    = 1'b0;
        DataIn      = '0;
        case (state)
            READ: begin
                busy        = 1'b1;
                DataAddress = src_ptr;
                ReadMem     = !reset;
            end
            WRITE: begin
                busy        = 1'b1;
                DataAddress = dst_ptr;
                WriteMem    = !reset;
                if (!reset) begin
                    DataIn = mode_r ? fill_r : hold;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - Directed self-checking bench for mem_copy_engine
`timescale 1ns/1ps
module tb_mem_copy_engine;

    logic       CLK = 1'b0;
    logic       reset;
    logic       start;
    logic       mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] len;
    logic [7:0] fill_value;
    logic       busy;
    logic       done;
    logic [7:0] DataAddress;
    logic       ReadMem;
    logic       WriteMem;
    logic [7:0] DataIn;
    logic [7:0] DataOut;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:255];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    int         n_wr = 0;
    int         n_rd = 0;
    int         n_done = 0;
    logic       overlap = 1'b0;
    logic [7:0] wr_log [0:1023];
    logic [7:0] rd_log [0:1023];

    always #5 CLK = ~CLK;

    mem_copy_engine #(.AW(8), .DW(8)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .DataAddress(DataAddress),
        .ReadMem    (ReadMem),
        .WriteMem   (WriteMem),
        .DataIn     (DataIn),
        .DataOut    (DataOut)
    );

    assign DataOut = mem[DataAddress];

    // Memory model plus bus monitor; the only process that writes mem.
    always @(posedge CLK) begin
        if (pl_en) mem[pl_addr] = pl_data;
        if (WriteMem) begin
            mem[DataAddress] = DataIn;
            wr_log[n_wr % 1024] = DataAddress;
            n_wr = n_wr + 1;
        end
        if (ReadMem) begin
            rd_log[n_rd % 1024] = DataAddress;
            n_rd = n_rd + 1;
        end
        if (ReadMem && WriteMem) overlap = 1'b1;
        if (done) n_done = n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge CLK);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge CLK);
        pl_en   = 1'b0;
    endtask

    // Issues a command and returns cycles to done and cycles with busy high.
    // glitch_at > 0 pulses a conflicting fill command at that cycle while busy.
    task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] fv, input int glitch_at,
                           output int lat, output int bcyc);
        int n;
        n    = 0;
        bcyc = 0;
        @(negedge CLK);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_value = fv;
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        forever begin
            @(negedge CLK);
            n++;
            if (busy) bcyc++;
            if (n == glitch_at) begin
                start = 1'b1; mode = 1'b1; dst_addr = 8'hC0; len = 8'd2; fill_value = 8'hEE;
            end else begin
                start = 1'b0;
            end
            if (done) break;
            if (n > 1000) begin
                check("done_timeout", 32'(n), 32'd0);
                break;
            end
        end
        start = 1'b0;
        lat = n;
    endtask

    initial begin
        int lat, bc, wr0, rd0, dn0;

        start = 0; mode = 0; src_addr = 0; dst_addr = 0; len = 0; fill_value = 0;
        reset = 1'b1;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobes", {30'd0, ReadMem, WriteMem}, 32'd0);
        check("rst_addr", 32'(DataAddress), 32'd0);
        check("rst_datain", 32'(DataIn), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);

        // Forward copy, with an ignored start pulse mid-transfer
        poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);
        dn0 = n_done;
        run_cmd(1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 3, lat, bc);
        check("fwd_latency", 32'(lat), 32'd9);
        check("fwd_busy_cycles", 32'(bc), 32'd8);
        check("fwd_m40", 32'(mem[8'h40]), 32'h11);
        check("fwd_m41", 32'(mem[8'h41]), 32'h22);
        check("fwd_m42", 32'(mem[8'h42]), 32'h33);
        check("fwd_m43", 32'(mem[8'h43]), 32'h44);
        repeat (6) @(negedge CLK);
        check("ignored_start_done_count", 32'(n_done - dn0), 32'd1);
        check("ignored_start_no_fill", 32'(mem[8'hC0]), 32'h00);
        check("ignored_start_idle", 32'(busy), 32'd0);

        // Overlapping backward copy
        poke(8'h10, 8'h01); poke(8'h11, 8'h02); poke(8'h12, 8'h03); poke(8'h13, 8'h04);
        wr0 = n_wr;
        run_cmd(1'b0, 8'h10, 8'h12, 8'd4, 8'h00, 0, lat, bc);
        check("bwd_first_wr_addr", 32'(wr_log[wr0 % 1024]), 32'h15);
        check("bwd_m12", 32'(mem[8'h12]), 32'h01);
        check("bwd_m13", 32'(mem[8'h13]), 32'h02);
        check("bwd_m14", 32'(mem[8'h14]), 32'h03);
        check("bwd_m15", 32'(mem[8'h15]), 32'h04);

        // Fill
        rd0 = n_rd;
        run_cmd(1'b1, 8'h00, 8'h80, 8'd3, 8'hA5, 0, lat, bc);
        check("fill_latency", 32'(lat), 32'd4);
        check("fill_no_reads", 32'(n_rd - rd0), 32'd0);
        check("fill_m80", 32'(mem[8'h80]), 32'hA5);
        check("fill_m81", 32'(mem[8'h81]), 32'hA5);
        check("fill_m82", 32'(mem[8'h82]), 32'hA5);
        check("fill_m83_untouched", 32'(mem[8'h83]), 32'h00);

        // Address wrap on the source side
        poke(8'hFE, 8'h5A); poke(8'hFF, 8'h6B); poke(8'h00, 8'h7C); poke(8'h01, 8'h8D);
        rd0 = n_rd;
        run_cmd(1'b0, 8'hFE, 8'h20, 8'd4, 8'h00, 0, lat, bc);
        check("wrap_rd0", 32'(rd_log[rd0 % 1024]), 32'hFE);
        check("wrap_rd1", 32'(rd_log[(rd0 + 1) % 1024]), 32'hFF);
        check("wrap_rd2", 32'(rd_log[(rd0 + 2) % 1024]), 32'h00);
        check("wrap_rd3", 32'(rd_log[(rd0 + 3) % 1024]), 32'h01);
        check("wrap_m20", 32'(mem[8'h20]), 32'h5A);
        check("wrap_m23", 32'(mem[8'h23]), 32'h8D);

        // Zero length
        rd0 = n_rd; wr0 = n_wr;
        run_cmd(1'b0, 8'h10, 8'h50, 8'd0, 8'h00, 0, lat, bc);
        check("len0_latency", 32'(lat), 32'd1);
        check("len0_no_strobes", 32'((n_rd - rd0) + (n_wr - wr0)), 32'd0);

        // Reset during the second write of a 4-byte copy
        poke(8'h30, 8'h50); poke(8'h31, 8'h51); poke(8'h32, 8'h52); poke(8'h33, 8'h53);
        @(negedge CLK);
        mode = 1'b0; src_addr = 8'h30; dst_addr = 8'h60; len = 8'd4; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (4) @(negedge CLK);
        check("pre_reset_in_write", 32'(WriteMem), 32'd1);
        dn0 = n_done;
        reset = 1'b1;
        #1;
        check("reset_drops_write", 32'(WriteMem), 32'd0);
        @(negedge CLK);
        reset = 1'b0;
        repeat (12) @(negedge CLK);
        check("abort_m60", 32'(mem[8'h60]), 32'h50);
        check("abort_m61", 32'(mem[8'h61]), 32'h00);
        check("abort_m62", 32'(mem[8'h62]), 32'h00);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_addr", 32'(DataAddress), 32'd0);
        check("abort_no_done", 32'(n_done - dn0), 32'd0);

        check("never_rd_and_wr", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
